// File: rtl/and_share_arbiter.sv
// and_share_arbiter: round-robin arbiter sharing one registered N-bit AND unit among NUM_REQ requesters
// ports: clk, rst_n (async, active-low); req_valid/req_ready/req_a/req_b per-requester request channel;
//        rsp_valid/rsp_ready/rsp_data/rsp_id response channel; busy (state != IDLE); done_cnt (completed responses)
module and_share_arbiter #(
  parameter int N = 5,
  parameter int NUM_REQ = 4,
  parameter int ID_W = ($clog2(NUM_REQ) > 0) ? $clog2(NUM_REQ) : 1,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*N-1:0] req_a,
  input  logic [NUM_REQ*N-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [N-1:0]         rsp_data,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy,
  output logic [CNT_W-1:0]     done_cnt
);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2;
  logic [1:0] state;
  logic [ID_W-1:0] rr_ptr, win, op_id;
  logic [N-1:0] op_a, op_b;
  logic any;
  // scan from the farthest offset down so the requester closest to rr_ptr wins
  always_comb begin
    win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) win = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
  end
  assign any = |req_valid;
  assign req_ready = (state == IDLE && any) ? NUM_REQ'(1) << win : '0;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      op_a <= '0;
      op_b <= '0;
      op_id <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_id <= '0;
      done_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          op_a <= req_a[win*N +: N];
          op_b <= req_b[win*N +: N];
          op_id <= win;
          state <= EXEC;
        end
        EXEC: begin
          rsp_data <= op_a & op_b;
          rsp_id <= op_id;
          rsp_valid <= 1'b1;
          state <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          rr_ptr <= (rsp_id == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id + 1'b1;
          done_cnt <= done_cnt + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_and_share_arbiter.sv
// tb_and_share_arbiter: directed scoreboard bench for and_share_arbiter
module tb_and_share_arbiter;
  logic clk = 1'b0, rst_n = 1'b0, rsp_ready = 1'b1, rsp_valid, busy;
  logic [3:0] req_valid = '0, req_ready;
  logic [19:0] req_a = '0, req_b = '0;
  logic [4:0] rsp_data;
  logic [1:0] rsp_id;
  logic [7:0] done_cnt;
  int checks = 0, errors = 0;
  logic [6:0] sb[$];
  and_share_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy), .done_cnt(done_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // monitor: every response handshake is popped against the scoreboard
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got id=%0d data=%b expected no response", rsp_id, rsp_data);
      end else begin
        logic [6:0] e;
        e = sb.pop_front();
        if ({rsp_id, rsp_data} !== e) begin
          errors++;
          $display("FAIL rsp: got id=%0d data=%b expected id=%0d data=%b", rsp_id, rsp_data, e[6:5], e[4:0]);
        end
      end
    end
  end
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 0);
  endtask
  // issue a request while the arbiter is idle; expects grant g and pushes the expected response
  task automatic req(input logic [3:0] v, input int g, input logic [4:0] a, input logic [4:0] b,
                     input logic [4:0] exp, input bit keep);
    wait_idle();
    req_valid = v;
    req_a = keep ? {4{a}} : {4{~a}};
    req_b = keep ? {4{b}} : {4{~b}};
    req_a[g*5 +: 5] = a;
    req_b[g*5 +: 5] = b;
    #1;
    chk($sformatf("grant%0d", g), 32'(req_ready), 32'(4'(1) << g));
    sb.push_back({2'(g), exp});
    @(posedge clk); #1;
    if (!keep) req_valid = '0;
  endtask
  initial begin
    logic [7:0] cnt;
    logic [6:0] held;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {req_ready, rsp_valid, rsp_data, rsp_id, busy, done_cnt}, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_rsp", {rsp_valid, busy}, 0);
    req(4'b0001, 0, 5'b00110, 5'b11111, 5'b00110, 0);
    chk("lat_exec", {busy, rsp_valid}, 2'b10);
    @(posedge clk); #1;
    chk("lat_resp", {rsp_valid, rsp_id, rsp_data}, {1'b1, 2'd0, 5'b00110});
    @(posedge clk); #1;
    chk("done_cnt1", 32'(done_cnt), 1);
    rsp_ready = 1'b0;
    req(4'b1000, 3, 5'b10101, 5'b01111, 5'b00101, 0);
    @(posedge clk); #1;
    held = {rsp_id, rsp_data};
    cnt = done_cnt;
    req_valid = 4'b0001;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_hold", {rsp_valid, rsp_id, rsp_data, req_ready, done_cnt}, {1'b1, held, 4'b0, cnt});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = '0;
    chk("bp_release", {rsp_valid, done_cnt}, {1'b0, cnt + 8'd1});
    for (int i = 0; i < 5; i++) req(4'b1111, i % 4, 5'b11110, 5'b10011, 5'b10010, 1);
    req_valid = '0;
    wait_idle();
    chk("rot_count", 32'(done_cnt), 7);
    req_valid = 4'b1111;
    req_a = '1;
    req_b = '1;
    #1;
    chk("pre_rst_grant", 32'(req_ready), 32'(4'b0010));
    @(posedge clk); #1;
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("midop_rst", {rsp_valid, busy, done_cnt}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("midop_no_rsp", 32'(rsp_valid), 0);
    req(4'b1111, 0, 5'b11011, 5'b10110, 5'b10010, 0);
    req(4'b0100, 2, 5'b01110, 5'b00111, 5'b00110, 0);
    req(4'b0010, 1, 5'b11111, 5'b01010, 5'b01010, 0);
    req(4'b1010, 3, 5'b10001, 5'b11001, 5'b10001, 0);
    req(4'b0011, 0, 5'b00001, 5'b00011, 5'b00001, 0);
    wait_idle();
    chk("final_cnt", 32'(done_cnt), 5);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
